// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM encoding and sizing helper for the debounce block
package debounce_pkg;
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel -- 2-flop synchronizer, LOW/RISE_WAIT/HIGH/FALL_WAIT FSM, sample counter, edge strobes
// Ports: clk, reset (sync, active-high), sample_en (sample strobe), btn_in (raw level),
//        btn_out (debounced level), btn_rise / btn_fall (one-clock accepted-edge strobes)
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic btn_in,
  output logic btn_out,
  output logic btn_rise,
  output logic btn_fall
);
  localparam int CW = cnt_w(STABLE_SAMPLES);
  localparam logic [CW-1:0] LIMIT = CW'(STABLE_SAMPLES);
  logic [1:0] sync_q;
  logic sync;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic lvl, out_n;
  assign sync = sync_q[1];
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      state  <= LOW;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_in};
      if (sample_en) begin
        state <= state_n;
        cnt   <= cnt_n;
      end
    end
  end
  // state[1] is the accepted level; state[0] marks a pending transition
  always_comb begin
    lvl     = state[1];
    cnt_inc = state[0] ? cnt + CW'(1) : CW'(1);
    state_n = lvl ? HIGH : LOW;
    cnt_n   = '0;
    if (sync != lvl) begin
      state_n = (cnt_inc == LIMIT) ? (lvl ? LOW : HIGH) : (lvl ? FALL_WAIT : RISE_WAIT);
      cnt_n   = (cnt_inc == LIMIT) ? '0 : cnt_inc;
    end
  end
  always_comb begin
    out_n = sample_en ? state_n[1] : btn_out;
  end
  // btn_out tracks the state register; strobes fire on the edge btn_out changes
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_out  <= 1'b0;
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
    end else begin
      btn_out  <= out_n;
      btn_rise <= out_n & ~btn_out;
      btn_fall <= ~out_n & btn_out;
    end
  end
endmodule

// File: rtl/debounce.sv
// debounce: WIDTH independent debounced button channels sharing one sample strobe
// Ports: clk, reset (sync, active-high), sample_en, btn_in[WIDTH] raw levels,
//        btn_out[WIDTH] debounced levels, btn_rise/btn_fall[WIDTH] one-clock edge strobes
module debounce
  import debounce_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_ch #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .sample_en(sample_en),
      .btn_in   (btn_in[i]),
      .btn_out  (btn_out[i]),
      .btn_rise (btn_rise[i]),
      .btn_fall (btn_fall[i])
    );
  end
endmodule

// File: tb/tb_debounce.sv
// tb_debounce: directed scoreboard bench for debounce with WIDTH=2, STABLE_SAMPLES=3
module tb_debounce;
  logic clk = 1'b0;
  logic reset, sample_en;
  logic [1:0] btn_in, btn_out, btn_rise, btn_fall;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [1:0] o;
    logic [1:0] r;
    logic [1:0] f;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  debounce #(.WIDTH(2), .STABLE_SAMPLES(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .btn_in   (btn_in),
    .btn_out  (btn_out),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One sample period: btn_in held 10 clocks, sample_en on the 10th edge.
  // Strobe cycles are counted per channel so a stretched or missing pulse shows up.
  task automatic period(input string tag, input logic [1:0] b, input logic [1:0] eo,
                        input logic [1:0] er, input logic [1:0] ef);
    logic [1:0] rc0, rc1, fc0, fc1;
    exp_t e;
    sb.push_back('{o: eo, r: er, f: ef});
    btn_in = b;
    rc0 = 0; rc1 = 0; fc0 = 0; fc1 = 0;
    for (int i = 1; i <= 10; i++) begin
      sample_en = (i == 10);
      tick();
      rc0 += 2'(btn_rise[0]);
      rc1 += 2'(btn_rise[1]);
      fc0 += 2'(btn_fall[0]);
      fc1 += 2'(btn_fall[1]);
    end
    sample_en = 1'b0;
    e = sb.pop_front();
    chk({tag, "_out"}, {2'b00, btn_out}, {2'b00, e.o});
    chk({tag, "_rise"}, {rc1, rc0}, {1'b0, e.r[1], 1'b0, e.r[0]});
    chk({tag, "_fall"}, {fc1, fc0}, {1'b0, e.f[1], 1'b0, e.f[0]});
  endtask
  initial begin
    reset = 1'b1;
    sample_en = 1'b0;
    btn_in = 2'b00;
    repeat (5) tick();
    chk("reset_state", {btn_out, btn_rise | btn_fall}, 4'h0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) period("idle", 2'b00, 2'b00, 2'b00, 2'b00);
    period("tog1", 2'b01, 2'b00, 2'b00, 2'b00);
    period("tog0", 2'b00, 2'b00, 2'b00, 2'b00);
    period("tog1b", 2'b01, 2'b00, 2'b00, 2'b00);
    period("tog0b", 2'b00, 2'b00, 2'b00, 2'b00);
    period("rise_s1", 2'b01, 2'b00, 2'b00, 2'b00);
    period("rise_s2", 2'b01, 2'b00, 2'b00, 2'b00);
    period("rise_s3", 2'b01, 2'b01, 2'b01, 2'b00);
    period("high_hold", 2'b01, 2'b01, 2'b00, 2'b00);
    period("fab_s1", 2'b00, 2'b01, 2'b00, 2'b00);
    period("fab_s2", 2'b00, 2'b01, 2'b00, 2'b00);
    period("fab_back", 2'b01, 2'b01, 2'b00, 2'b00);
    period("fall_s1", 2'b00, 2'b01, 2'b00, 2'b00);
    period("fall_s2", 2'b00, 2'b01, 2'b00, 2'b00);
    period("fall_s3", 2'b00, 2'b00, 2'b00, 2'b01);
    period("both_s1", 2'b11, 2'b00, 2'b00, 2'b00);
    period("both_s2", 2'b11, 2'b00, 2'b00, 2'b00);
    period("both_s3", 2'b11, 2'b11, 2'b11, 2'b00);
    period("bfall_s1", 2'b00, 2'b11, 2'b00, 2'b00);
    period("bfall_s2", 2'b00, 2'b11, 2'b00, 2'b00);
    period("bfall_s3", 2'b00, 2'b00, 2'b00, 2'b11);
    // sample_en held high: sync sees the new level 2 edges later, then 3 samples
    sample_en = 1'b1;
    btn_in = 2'b10;
    repeat (4) tick();
    chk("cont_before", {btn_out, btn_rise}, 4'b0000);
    tick();
    chk("cont_accept", {btn_out, btn_rise}, 4'b1010);
    tick();
    chk("cont_after", {btn_out, btn_rise}, 4'b1000);
    sample_en = 1'b0;
    period("rst_s1", 2'b11, 2'b10, 2'b00, 2'b00);
    period("rst_s2", 2'b11, 2'b10, 2'b00, 2'b00);
    reset = 1'b1;
    tick();
    tick();
    chk("mid_reset", {btn_out, btn_rise | btn_fall}, 4'h0);
    reset = 1'b0;
    period("post_s1", 2'b11, 2'b00, 2'b00, 2'b00);
    period("post_s2", 2'b11, 2'b00, 2'b00, 2'b00);
    period("post_s3", 2'b11, 2'b11, 2'b11, 2'b00);
    period("post_hold", 2'b11, 2'b11, 2'b00, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/debounce.md
DEBOUNCE -- requirements
Module: debounce

Interface
REQ-001 Parameter: WIDTH, default 4, number of independent button channels (1..32).
REQ-002 Parameter: STABLE_SAMPLES, default 3, consecutive agreeing samples required to accept a new level (1..15).
REQ-003 Port: clk  input  1  system clock; single clock domain for the block.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: sample_en  input  1  one-clock sample strobe, driven by the upstream 15 ms pulse generator's pulse output.
REQ-006 Port: btn_in  input  WIDTH  raw, asynchronous, bouncing button levels.
REQ-007 Port: btn_out  output  WIDTH  debounced level per channel.
REQ-008 Port: btn_rise  output  WIDTH  one-clock strobe per channel on accepted 0->1 transition.
REQ-009 Port: btn_fall  output  WIDTH  one-clock strobe per channel on accepted 1->0 transition.

Function
REQ-010 Each btn_in bit SHALL pass through a 2-flop synchronizer; only the synchronized value (sync) is used downstream.
REQ-011 Each channel SHALL run an independent FSM with states LOW, RISE_WAIT, HIGH, FALL_WAIT, plus a sample counter of width ceil(log2(STABLE_SAMPLES+1)).
REQ-012 The FSM and counter SHALL change only on clock edges where sample_en=1; on all other cycles they hold.
REQ-013 LOW: sync=1 -> RISE_WAIT, count=1; sync=0 -> stay, count=0.
REQ-014 RISE_WAIT: sync=1 -> count+1; sync=0 -> LOW, count=0.
REQ-015 HIGH/FALL_WAIT SHALL mirror REQ-013/REQ-014 with levels inverted (HIGH: sync=0 -> FALL_WAIT, count=1; FALL_WAIT: sync=1 -> HIGH, count=0).
REQ-016 When an agreeing sample makes count equal STABLE_SAMPLES, the channel SHALL enter HIGH (from RISE_WAIT) or LOW (from FALL_WAIT) and clear count; with STABLE_SAMPLES=1, LOW->HIGH and HIGH->LOW are direct, with no WAIT-state dwell.
REQ-017 btn_out SHALL be registered: 1 in HIGH and FALL_WAIT, 0 in LOW and RISE_WAIT.
REQ-018 btn_rise (btn_fall) SHALL be 1 for exactly the one clock in which btn_out first reads 1 (0), then return to 0 regardless of sample_en.
REQ-019 Latency: btn_out SHALL update on the clock edge that samples the STABLE_SAMPLES-th consecutive agreeing sample_en, where sync reflects btn_in from 2 clocks earlier.
REQ-020 A disagreeing sample in a WAIT state SHALL abort the transition with no strobe; btn_out is unchanged.
REQ-021 Counter SHALL never exceed STABLE_SAMPLES (no wrap).
REQ-022 Channels SHALL not interact; simultaneous transitions on several channels produce simultaneous independent strobes.
REQ-023 sample_en held high continuously SHALL be legal and behave as a sample every clock.

Reset
REQ-024 While reset=1 (priority over sample_en): synchronizer flops=0, state=LOW, count=0, btn_out=0, btn_rise=0, btn_fall=0.
REQ-025 Reset asserted mid-transition SHALL discard the pending transition with no strobe.
REQ-026 A button held at 1 through reset release SHALL produce a normal debounced rise (btn_rise strobe) after STABLE_SAMPLES samples.

Structure
REQ-027 FSM state encoding constants (2-bit LOW=0, RISE_WAIT=1, HIGH=2, FALL_WAIT=3) SHALL live in shared package debounce_pkg.
REQ-028 Per-channel logic (synchronizer, FSM, counter, strobes) SHALL be sub-module debounce_ch, instantiated WIDTH times by generate.
REQ-029 debounce SHALL contain no logic beyond instantiation and bus wiring.

Verification (WIDTH=2, STABLE_SAMPLES=3, bench drives sample_en every 10 clocks)
REQ-030 Reset 5 clocks, btn_in=00 -> btn_out=00, no strobes for 100 clocks.
REQ-031 btn_in[0] 0->1 held -> btn_out[0]=1 on the 3rd sample_en edge after sync=1; btn_rise[0]=1 exactly one clock; channel 1 untouched.
REQ-032 btn_in[0] toggles 1,0,1 across successive samples -> no btn_out change, no strobes; counter returns to 0.
REQ-033 From HIGH, btn_in[0]=0 for 2 samples then 1 -> stays HIGH, no btn_fall; then 0 for 3 samples -> btn_out[0]=0, btn_fall[0] one clock.
REQ-034 Both channels rise together -> btn_rise=11 in the same single clock.
REQ-035 Reset pulsed during RISE_WAIT with count=2 -> btn_out=0, no strobe; with btn_in held 1, rise strobe after 3 further samples.
